dds_wave_gen: RTL and testbench
===============================

Name: dds_wave_gen

Overview:
Parametrised direct-digital-synthesis waveform generator for the AD/DA signal path. It is the successor to the fixed 1024x8 square-wave table. It runs a phase accumulator with programmable frequency, duty and amplitude, and outputs sine, square, triangle or sawtooth in offset-binary. Sine samples come from an external synchronous ROM IP (1-cycle read, no output register); the other shapes are computed in logic. Configuration is accepted by handshake and applied glitch-free at the phase wrap.

Parameters:
PHASE_WIDTH, 32, phase accumulator and FTW width.
ADDR_WIDTH, 10, sine ROM address width; phase top bits; must satisfy ADDR_WIDTH >= DATA_WIDTH+1.
DATA_WIDTH, 8, sample width (offset binary, mid-scale = 2^(DATA_WIDTH-1)).

Ports:
clk  in  1  single clock.
rst  in  1  synchronous, active-high reset.
enable  in  1  run generator; low = idle at mid-scale.
cfg_valid  in  1  config offered.
cfg_ready  out  1  config accepted when valid&ready.
cfg_mode  in  2  0 sine, 1 square, 2 triangle, 3 sawtooth.
cfg_ftw  in  PHASE_WIDTH  frequency tuning word.
cfg_duty  in  ADDR_WIDTH  square high-threshold, compared against the phase address.
cfg_amp  in  DATA_WIDTH+1  gain; 2^DATA_WIDTH = unity; larger values saturate to unity.
rom_addr  out  ADDR_WIDTH  sine ROM address.
rom_data  in  DATA_WIDTH  sine ROM data, valid one cycle after rom_addr.
dout  out  DATA_WIDTH  sample.
dout_valid  out  1  sample valid.

Behaviour:
- Reset (rst=1 at clk edge), regardless of state:
  - phase=0, state IDLE.
  - active config = {mode 0, ftw 0, duty 2^(ADDR_WIDTH-1), amp unity}; shadow cleared.
  - dout = mid-scale, dout_valid=0, cfg_ready=1.
- State machine:
  - IDLE: phase held at 0, dout = mid-scale, dout_valid=0.
    - Accepted config is applied to the active registers the next cycle.
    - enable=1 -> RUN.
  - RUN: phase <= phase + ftw_active each cycle (mod 2^PHASE_WIDTH); wrap = carry out of the add.
    - Config accept -> PEND.
    - enable=0 -> IDLE.
  - PEND: cfg_ready=0; the accumulator keeps running on the old config.
    - On the wrap cycle, shadow -> active, effective from the next accumulation -> RUN.
    - enable=0 in PEND: shadow applied immediately -> IDLE.
- cfg_ready=1 in IDLE and RUN, 0 in PEND; combinational from state only.
- addr = phase[PHASE_WIDTH-1 -: ADDR_WIDTH]; rom_addr = addr, driven from the phase register.
- Raw sample (registered one cycle later, aligned with rom_data):
  - sine: rom_data.
  - square: (addr < duty) ? 2^DW-1 : 0. duty=0 gives constant 0.
  - sawtooth: addr[AW-1 -: DW].
  - triangle: addr[AW-1] ? ~addr[AW-2 -: DW] : addr[AW-2 -: DW].
- Scale stage: dout = mid + (((raw - mid) signed * amp) >>> DATA_WIDTH).
  - Arithmetic shift, floor rounding.
  - Result is always within [0, 2^DW-1]; no clipping needed.
- Latency: phase register value P at cycle n -> dout reflects P at n+2.
  - dout_valid rises 2 cycles after the first RUN cycle and falls 2 cycles after leaving RUN/PEND.
  - While draining, dout carries pipeline samples; once dout_valid=0, dout = mid-scale.
- Mode change at the wrap: the first sample of the new mode is the one from phase 0+ftw_old overflow residue. No mixed-mode sample ever appears.
- Simultaneous cfg accept and wrap in RUN: the new config waits for the next wrap (goes to PEND).
- ftw=0 in RUN: output is constant; PEND never completes until enable drops.

Decomposition:
- Package dds_pkg: mode constants (MODE_SINE/SQUARE/TRI/SAW), state encoding (IDLE/RUN/PEND), helper function for unity amp = 1<<DATA_WIDTH.
- Sub-module dds_amp_scale: the signed multiply/shift/offset register stage.
- The top holds the FSM, accumulator, shape logic and ROM alignment.

Test Plan:
- Reset: hold rst 3 cycles with enable=1 -> dout=0x80, dout_valid=0, cfg_ready=1, rom_addr=0.
- Square, ftw=0x0040_0000 (addr +1/cycle), duty=256, amp=256 -> after 2-cycle latency, 256 samples 0xFF then 768 samples 0x00, period 1024.
- Sawtooth, ftw=0x0100_0000 (addr +4/cycle) -> dout = 0x00,0x01,...,0xFF, wrapping to 0x00, one step per cycle.
- Square, duty=512, amp=128 -> levels alternate 0xBF and 0x40, each for 512 cycles.
- In RUN, offer ftw=0x0080_0000 mid-period -> cfg_ready drops the next cycle; a second cfg_valid is stalled; new step size appears from the cycle after the carry; cfg_ready returns to 1.
- Sine mode with a ROM model (1-cycle latency): dout matches ROM[addr] 2 cycles after phase. Drop enable mid-period -> dout_valid=0 after 2 cycles, dout=0x80, phase=0. Pending config is applied immediately.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and helpers for the DDS waveform generator.
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SAW    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  // Gain code that represents x1.0 for a given sample width.
  function automatic int unsigned unity_amp(input int data_width);
    return 32'd1 << data_width;
  endfunction

endpackage

// File: rtl/dds_amp_scale.sv
// Output gain stage: scales an offset-binary sample about mid-scale and registers it.
module dds_amp_scale
  import dds_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic [DATA_WIDTH:0]   amp,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid
);

  localparam int PW = 2 * DATA_WIDTH + 3;
  localparam logic [DATA_WIDTH-1:0] MID   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH:0]   UNITY = (DATA_WIDTH+1)'(unity_amp(DATA_WIDTH));

  logic [DATA_WIDTH:0]    amp_sat;
  logic signed [PW-1:0]   centred;
  logic signed [PW-1:0]   gain;
  logic signed [PW-1:0]   product;
  logic [DATA_WIDTH-1:0]  scaled;

  // Saturate gain to unity and scale the centred sample; floor via arithmetic shift
  always_comb begin
    amp_sat = (amp > UNITY) ? UNITY : amp;
    centred = $signed(PW'(sample)) - $signed(PW'(MID));
    gain    = $signed(PW'(amp_sat));
    product = centred * gain;
    scaled  = DATA_WIDTH'(product >>> DATA_WIDTH) + MID;
  end

  // Register the scaled sample; empty pipeline slots present mid-scale
  always_ff @(posedge clk) begin
    if (rst || !sample_valid) begin
      dout       <= MID;
      dout_valid <= 1'b0;
    end else begin
      dout       <= scaled;
      dout_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator, config handshake, shape logic, ROM alignment.
//
// state | meaning
// IDLE  | phase parked at 0, output mid-scale, accepted config loads straight into active
// RUN   | accumulating, ready for a new config
// PEND  | accumulating on old config, new config held in shadow until the next wrap
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [1:0]             cfg_mode,
  input  logic [PHASE_WIDTH-1:0] cfg_ftw,
  input  logic [ADDR_WIDTH-1:0]  cfg_duty,
  input  logic [DATA_WIDTH:0]    cfg_amp,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_data,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid
);

  localparam logic [ADDR_WIDTH-1:0] DUTY_RST  = {1'b1, {(ADDR_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH:0]   AMP_UNITY = (DATA_WIDTH+1)'(unity_amp(DATA_WIDTH));

  state_e                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_sum;
  logic                   wrap;
  logic                   cfg_accept;
  logic                   load_direct, load_shadow, apply_shadow, advance;

  mode_e                  act_mode, shd_mode;
  logic [PHASE_WIDTH-1:0] act_ftw, shd_ftw;
  logic [ADDR_WIDTH-1:0]  act_duty, shd_duty;
  logic [DATA_WIDTH:0]    act_amp, shd_amp;

  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  shape_d, shape_q, raw;
  mode_e                  mode_s1;
  logic [DATA_WIDTH:0]    amp_s1;
  logic                   valid_s1;

  assign {wrap, phase_sum} = {1'b0, phase_q} + {1'b0, act_ftw};
  assign cfg_ready  = (state_q != PEND);
  assign cfg_accept = cfg_valid & cfg_ready;
  assign addr       = phase_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign rom_addr   = addr;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and datapath controls; a wrap coinciding with an accept still waits in PEND
  always_comb begin
    state_d      = state_q;
    load_direct  = 1'b0;
    load_shadow  = 1'b0;
    apply_shadow = 1'b0;
    advance      = 1'b0;
    case (state_q)
      IDLE: begin
        load_direct = cfg_accept;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_d     = IDLE;
          load_direct = cfg_accept;
        end else begin
          advance = 1'b1;
          if (cfg_accept) begin
            load_shadow = 1'b1;
            state_d     = PEND;
          end
        end
      end
      PEND: begin
        if (!enable) begin
          state_d      = IDLE;
          apply_shadow = 1'b1;
        end else begin
          advance = 1'b1;
          if (wrap) begin
            apply_shadow = 1'b1;
            state_d      = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Phase accumulator plus active and shadow configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= '0;
      act_mode <= MODE_SINE;
      act_ftw  <= '0;
      act_duty <= DUTY_RST;
      act_amp  <= AMP_UNITY;
      shd_mode <= MODE_SINE;
      shd_ftw  <= '0;
      shd_duty <= '0;
      shd_amp  <= '0;
    end else begin
      phase_q <= advance ? phase_sum : '0;
      if (load_direct) begin
        act_mode <= mode_e'(cfg_mode);
        act_ftw  <= cfg_ftw;
        act_duty <= cfg_duty;
        act_amp  <= cfg_amp;
      end else if (apply_shadow) begin
        act_mode <= shd_mode;
        act_ftw  <= shd_ftw;
        act_duty <= shd_duty;
        act_amp  <= shd_amp;
      end
      if (load_shadow) begin
        shd_mode <= mode_e'(cfg_mode);
        shd_ftw  <= cfg_ftw;
        shd_duty <= cfg_duty;
        shd_amp  <= cfg_amp;
      end
    end
  end

  // Computed shapes from the current phase address
  always_comb begin
    shape_d = '0;
    case (act_mode)
      MODE_SQUARE: shape_d = (addr < act_duty) ? '1 : '0;
      MODE_TRI:    shape_d = addr[ADDR_WIDTH-1] ? ~addr[ADDR_WIDTH-2 -: DATA_WIDTH]
                                                :  addr[ADDR_WIDTH-2 -: DATA_WIDTH];
      MODE_SAW:    shape_d = addr[ADDR_WIDTH-1 -: DATA_WIDTH];
      default:     shape_d = '0;
    endcase
  end

  // Delay computed shape, mode and gain one cycle so they line up with rom_data
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_s1 <= 1'b0;
      mode_s1  <= MODE_SINE;
      amp_s1   <= '0;
      shape_q  <= '0;
    end else begin
      valid_s1 <= (state_q != IDLE);
      mode_s1  <= act_mode;
      amp_s1   <= act_amp;
      shape_q  <= shape_d;
    end
  end

  assign raw = (mode_s1 == MODE_SINE) ? rom_data : shape_q;

  dds_amp_scale #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_amp_scale (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (valid_s1),
    .sample       (raw),
    .amp          (amp_s1),
    .dout         (dout),
    .dout_valid   (dout_valid)
  );

endmodule

// File: tb/tb_dds_wave_gen.sv
// Bench for dds_wave_gen: directed scenarios plus random stimulus against a behavioural model.
module tb_dds_wave_gen;

  localparam int PW  = 32;
  localparam int AW  = 10;
  localparam int DW  = 8;
  localparam int MID = 1 << (DW - 1);
  localparam int ONE = 1 << DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_mode;
  logic [PW-1:0] cfg_ftw;
  logic [AW-1:0] cfg_duty;
  logic [DW:0]   cfg_amp;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] dout;
  logic          dout_valid;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  int rom [1 << AW];
  int samp [1100];

  // model state: 0 idle, 1 run, 2 pend
  int          m_st;
  logic [PW-1:0] m_phase, m_ftw, s_ftw;
  int          m_mode, m_duty, m_amp, s_mode, s_duty, s_amp;
  bit          p1_valid, e_valid;
  int          p1_dout, e_dout;

  dds_wave_gen #(.PHASE_WIDTH(PW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mode   (cfg_mode),
    .cfg_ftw    (cfg_ftw),
    .cfg_duty   (cfg_duty),
    .cfg_amp    (cfg_amp),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  // synchronous ROM, one cycle read latency
  always @(posedge clk) rom_data <= DW'(rom[rom_addr]);

  function automatic int scale(input int raw, input int amp);
    int a, d;
    a = (amp > ONE) ? ONE : amp;
    d = (raw - MID) * a;
    if (d >= 0) return MID + d / ONE;
    return MID - ((-d + ONE - 1) / ONE);
  endfunction

  function automatic int shape(input int mode, input logic [PW-1:0] ph, input int duty);
    int a;
    a = int'(ph >> (PW - AW));
    case (mode)
      0: return rom[a];
      1: return (a < duty) ? ONE - 1 : 0;
      2: return (a < (1 << (AW - 1))) ? (a >> (AW - 1 - DW))
                                      : (ONE - 1) - ((a - (1 << (AW - 1))) >> (AW - 1 - DW));
      default: return a >> (AW - DW);
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // behavioural model, advanced on each clock edge from the sampled inputs
  always @(posedge clk) begin : model
    logic [PW:0] sum;
    bit acc, wr;
    if (rst) begin
      m_st = 0; m_phase = '0;
      m_mode = 0; m_ftw = '0; m_duty = 1 << (AW - 1); m_amp = ONE;
      s_mode = 0; s_ftw = '0; s_duty = 0; s_amp = 0;
      p1_valid = 1'b0; p1_dout = MID; e_valid = 1'b0; e_dout = MID;
    end else begin
      e_valid  = p1_valid;
      e_dout   = p1_valid ? p1_dout : MID;
      p1_valid = (m_st != 0);
      p1_dout  = scale(shape(m_mode, m_phase, m_duty), m_amp);
      acc = cfg_valid && (m_st != 2);
      sum = {1'b0, m_phase} + {1'b0, m_ftw};
      wr  = sum[PW];
      case (m_st)
        0: begin
          if (acc) begin m_mode = cfg_mode; m_ftw = cfg_ftw; m_duty = cfg_duty; m_amp = cfg_amp; end
          if (enable) m_st = 1;
        end
        1: begin
          if (!enable) begin
            if (acc) begin m_mode = cfg_mode; m_ftw = cfg_ftw; m_duty = cfg_duty; m_amp = cfg_amp; end
            m_st = 0; m_phase = '0;
          end else begin
            m_phase = sum[PW-1:0];
            if (acc) begin
              s_mode = cfg_mode; s_ftw = cfg_ftw; s_duty = cfg_duty; s_amp = cfg_amp;
              m_st = 2;
            end
          end
        end
        default: begin
          if (!enable) begin
            m_mode = s_mode; m_ftw = s_ftw; m_duty = s_duty; m_amp = s_amp;
            m_st = 0; m_phase = '0;
          end else begin
            m_phase = sum[PW-1:0];
            if (wr) begin
              m_mode = s_mode; m_ftw = s_ftw; m_duty = s_duty; m_amp = s_amp;
              m_st = 1;
            end
          end
        end
      endcase
    end
  end

  // compare DUT against model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("dout", dout, e_dout);
      check("dout_valid", dout_valid, e_valid);
      check("cfg_ready", cfg_ready, (m_st != 2));
      check("rom_addr", rom_addr, m_phase >> (PW - AW));
    end
  end

  task automatic set_cfg(input int mode, input logic [PW-1:0] ftw, input int duty, input int amp);
    cfg_mode = 2'(mode);
    cfg_ftw  = ftw;
    cfg_duty = AW'(duty);
    cfg_amp  = (DW+1)'(amp);
  endtask

  task automatic load_idle(input int mode, input logic [PW-1:0] ftw, input int duty, input int amp);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    set_cfg(mode, ftw, duty, amp);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    enable = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!dout_valid && k < 64) begin
      @(negedge clk);
      k++;
    end
    check(name, dout_valid, 1);
  endtask

  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      samp[i] = dout;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, k, a0, a1, bad;
    int ah [64];
    for (int i = 0; i < (1 << AW); i++) rom[i] = $urandom_range(0, ONE - 1);
    rst = 1'b1; enable = 1'b1; cfg_valid = 1'b0;
    set_cfg(0, '0, 0, 0);
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_dout", dout, 8'h80);
    check("rst_valid", dout_valid, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_rom_addr", rom_addr, 0);

    // pin the model with hand-computed values
    check("pin_scale_half_hi", scale(255, 128), 8'hBF);
    check("pin_scale_half_lo", scale(0, 128), 8'h40);
    check("pin_scale_sat", scale(255, 400), 255);
    check("pin_scale_zero", scale(0, 0), 8'h80);
    check("pin_tri_top", shape(2, 32'hFFC0_0000, 0), 0);
    check("pin_tri_mid", shape(2, 32'h7FC0_0000, 0), 255);
    check("pin_saw_top", shape(3, 32'hFFFF_FFFF, 0), 255);
    check("pin_sq_duty0", shape(1, 32'h0, 0), 0);

    rst = 1'b0;
    enable = 1'b0;

    // square, duty 256, unity gain
    load_idle(1, 32'h0040_0000, 256, 256);
    wait_valid("sq_start");
    collect(1025);
    cnt = 0;
    for (int i = 0; i < 1024; i++) if (samp[i] == 255) cnt++;
    check("sq_first", samp[0], 8'hFF);
    check("sq_high_count", cnt, 256);
    check("sq_last_high", samp[255], 8'hFF);
    check("sq_first_low", samp[256], 8'h00);
    check("sq_period", samp[1024], 8'hFF);

    // sawtooth, one code per cycle
    load_idle(3, 32'h0100_0000, 0, 256);
    wait_valid("saw_start");
    collect(300);
    bad = 0;
    for (int i = 1; i < 300; i++) if (samp[i] != ((samp[i-1] + 1) & 255)) bad++;
    check("saw_first", samp[0], 0);
    check("saw_steps", bad, 0);
    check("saw_top", samp[255], 255);
    check("saw_wrap", samp[256], 0);

    // square, duty 512, half gain
    load_idle(1, 32'h0040_0000, 512, 128);
    wait_valid("sq2_start");
    collect(1025);
    check("sq2_first", samp[0], 8'hBF);
    check("sq2_last_high", samp[511], 8'hBF);
    check("sq2_first_low", samp[512], 8'h40);
    check("sq2_last_low", samp[1023], 8'h40);
    check("sq2_period", samp[1024], 8'hBF);

    // config handshake while running: pend until wrap, second offer stalled
    repeat (100) @(negedge clk);
    set_cfg(1, 32'h0080_0000, 512, 128);
    cfg_valid = 1'b1;
    @(negedge clk);
    check("pend_ready_low", cfg_ready, 0);
    set_cfg(3, 32'h0200_0000, 0, 256);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cfg_ready) cnt++;
    end
    check("pend_stall", cnt, 0);
    cfg_valid = 1'b0;
    k = 0;
    while (!cfg_ready && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("pend_release", cfg_ready, 1);
    a0 = rom_addr;
    @(negedge clk);
    a1 = rom_addr;
    check("new_step", (a1 - a0) & ((1 << AW) - 1), 2);

    // sine through ROM, then drop enable with a pending config
    load_idle(0, 32'h0031_0000, 0, 256);
    wait_valid("sine_start");
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      ah[i] = rom_addr;
      if (i >= 2 && int'(dout) != rom[ah[i-2]]) bad++;
      @(negedge clk);
    end
    check("sine_rom_align", bad, 0);
    set_cfg(3, 32'h0100_0000, 0, 256);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("sine_pend", cfg_ready, 0);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("drain_valid", dout_valid, 0);
    check("drain_dout", dout, 8'h80);
    check("drain_addr", rom_addr, 0);
    check("drain_ready", cfg_ready, 1);
    enable = 1'b1;
    wait_valid("applied_start");
    check("applied_first", dout, 0);
    @(negedge clk);
    check("applied_second", dout, 1);

    // random traffic
    enable = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      cfg_valid = ($urandom_range(0, 11) == 0);
      cfg_mode  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       cfg_ftw = $urandom;
        1:       cfg_ftw = $urandom >> 6;
        2:       cfg_ftw = $urandom >> 12;
        default: cfg_ftw = '0;
      endcase
      cfg_duty = AW'($urandom_range(0, (1 << AW) - 1));
      cfg_amp  = (DW+1)'($urandom_range(0, (2 << DW) - 1));
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
